// File: rtl/spectrum_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_ram_reader
// Purpose  : Read-side sequencer for a spectrum RAM whose read port is
//            combinational. A start pulse sweeps bins 0..DEPTH-1. Each word is
//            registered and streamed on a valid/ready interface, together with
//            its bin index and a last flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  width of one RAM word / stream word
//   DEPTH       number of bins swept (>= 2); ADDRW = $clog2(DEPTH)
// Ports
//   clk          clock for all logic
//   rst_n        asynchronous active-low reset
//   start        begin a sweep (honoured only when idle)
//   abort        cancel an active sweep, no done pulse
//   busy         high while a sweep is scanning or draining
//   done         one-cycle pulse after the last word is accepted
//   ram_rd_addr  registered RAM read address
//   ram_rd_data  RAM read data (combinational from ram_rd_addr)
//   out_data     stream word
//   out_index    bin index of out_data
//   out_last     marks the word of bin DEPTH-1
//   out_valid    stream valid
//   out_ready    stream ready
// Optional feature (macro SPECTRUM_READER_PEAK_EN)
//   peak_value   largest word of the sweep (lowest index wins ties)
//   peak_index   bin index of peak_value
//   peak_valid   peak result belongs to a completed sweep
// ============================================================================
module spectrum_ram_reader #(
   parameter  int DATA_WIDTH = 4,
   parameter  int DEPTH      = 256,
   localparam int ADDRW      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDRW-1:0]      ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDRW-1:0]      out_index,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef SPECTRUM_READER_PEAK_EN
   ,
   output logic [DATA_WIDTH-1:0] peak_value,
   output logic [ADDRW-1:0]      peak_index,
   output logic                  peak_valid
`endif
);

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state, state_d;
   logic [ADDRW-1:0]      addr_d, index_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  last_d, valid_d, done_d, busy_d;
   logic                  load, at_last;

   // A new word may be captured when the output register is empty or is
   // being emptied on this same edge.
   assign load    = (state == SCAN) && (!out_valid || out_ready);
   assign at_last = (ram_rd_addr == LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ram_rd_addr <= '0;
         out_data    <= '0;
         out_index   <= '0;
         out_last    <= 1'b0;
         out_valid   <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         ram_rd_addr <= addr_d;
         out_data    <= data_d;
         out_index   <= index_d;
         out_last    <= last_d;
         out_valid   <= valid_d;
         done        <= done_d;
         busy        <= busy_d;
      end
   end

   always_comb begin
      state_d = state;
      addr_d  = ram_rd_addr;
      data_d  = out_data;
      index_d = out_index;
      last_d  = out_last;
      valid_d = out_valid;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               addr_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            // abort wins over a capture in the same cycle
            if (abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               addr_d  = '0;
            end else if (load) begin
               data_d  = ram_rd_data;
               index_d = ram_rd_addr;
               last_d  = at_last;
               valid_d = 1'b1;
               if (at_last) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = ram_rd_addr + ADDRW'(1);
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               addr_d  = '0;
            end else if (out_valid && out_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b1;
               addr_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // busy is registered from the next state so it tracks SCAN/DRAIN exactly
   assign busy_d = (state_d != IDLE);

`ifdef SPECTRUM_READER_PEAK_EN
   logic peak_upd;

   // Index 0 always seeds the peak; a strict compare keeps the lower index on ties.
   assign peak_upd = load && !abort &&
                     ((ram_rd_addr == '0) || (ram_rd_data > peak_value));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_value <= '0;
         peak_index <= '0;
         peak_valid <= 1'b0;
      end else begin
         if (peak_upd) begin
            peak_value <= ram_rd_data;
            peak_index <= ram_rd_addr;
         end
         if (done_d) begin
            peak_valid <= 1'b1;
         end else if (((state == IDLE) && start) || ((state != IDLE) && abort)) begin
            peak_valid <= 1'b0;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spectrum_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spectrum_ram_reader
// Purpose  : Self-checking bench for spectrum_ram_reader with DEPTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spectrum_ram_reader;

   localparam int DW    = 4;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          out_ready = 1'b0;
   logic          busy, done, out_last, out_valid;
   logic [AW-1:0] ram_rd_addr, out_index;
   logic [DW-1:0] ram_rd_data, out_data;
   logic [DW-1:0] ram [DEPTH];
`ifdef SPECTRUM_READER_PEAK_EN
   logic [DW-1:0] peak_value;
   logic [AW-1:0] peak_index;
   logic          peak_valid;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign ram_rd_data = ram[ram_rd_addr];

   spectrum_ram_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data), .out_data(out_data), .out_index(out_index),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SPECTRUM_READER_PEAK_EN
      , .peak_value(peak_value), .peak_index(peak_index), .peak_valid(peak_valid)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_index(input logic [AW-1:0] k);
      int n = 0;
      while (!(out_valid && out_index == k) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeout_fail("wait_index");
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeout_fail("wait_done");
   endtask

   // ------------------------------------------------------------------
   // Frame-level model: tracks whether a sweep is in progress, which bin
   // must be accepted next, and when done is owed. Checked every cycle.
   // ------------------------------------------------------------------
   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   int            m_idx  = 0;
   logic          p_hold = 1'b0;
   logic [DW-1:0] p_data = '0;
   logic [AW-1:0] p_index = '0;
   logic          p_last = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset out_valid", 32'(out_valid), 32'd0);
         check("reset busy", 32'(busy), 32'd0);
         check("reset done", 32'(done), 32'd0);
         check("reset ram_rd_addr", 32'(ram_rd_addr), 32'd0);
         check("reset out_last", 32'(out_last), 32'd0);
         m_busy = 1'b0;
         m_done = 1'b0;
         m_idx  = 0;
         p_hold = 1'b0;
      end else begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         if (p_hold) begin
            check("stall valid", 32'(out_valid), 32'd1);
            check("stall data", 32'(out_data), 32'(p_data));
            check("stall index", 32'(out_index), 32'(p_index));
            check("stall last", 32'(out_last), 32'(p_last));
         end
         if (out_valid) begin
            check("data vs ram", 32'(out_data), 32'(ram[out_index]));
            check("last flag", 32'(out_last), 32'(out_index == AW'(DEPTH - 1)));
         end
         // predict the frame state after the coming edge
         m_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1'b1;
               m_idx  = 0;
            end
         end else if (abort) begin
            m_busy = 1'b0;
            m_idx  = 0;
         end else if (out_valid && out_ready) begin
            check("order", 32'(out_index), 32'(m_idx));
            if (int'(out_index) == DEPTH - 1) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_idx  = 0;
            end else begin
               m_idx = m_idx + 1;
            end
         end
         p_hold  = out_valid && !out_ready && !abort;
         p_data  = out_data;
         p_index = out_index;
         p_last  = out_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   bit       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int       got_idx [$];
   int       got_dat [$];
   int       dones;
   int       n;
   int       pk_val, pk_idx;

   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 3);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("por out_valid", 32'(out_valid), 32'd0);
      check("por out_data", 32'(out_data), 32'd0);
      check("por out_index", 32'(out_index), 32'd0);
      rst_n = 1'b1;
      tick();

      // ---- full sweep, ready held high ----
      out_ready = 1'b1;
      start = 1'b1;
      tick();                       // edge E
      start = 1'b0;
      check("t1 busy after E", 32'(busy), 32'd1);
      check("t1 valid after E", 32'(out_valid), 32'd0);
      for (int k = 0; k < DEPTH; k++) begin
         tick();                    // edge E+1+k
         check("t1 valid", 32'(out_valid), 32'd1);
         check("t1 index", 32'(out_index), 32'(k));
         check("t1 data", 32'(out_data), 32'(k + 3));
         check("t1 last", 32'(out_last), 32'(k == 7));
         check("t1 no done", 32'(done), 32'd0);
      end
      tick();                       // edge E+9
      check("t1 done", 32'(done), 32'd1);
      check("t1 busy end", 32'(busy), 32'd0);
      check("t1 valid end", 32'(out_valid), 32'd0);
      tick();
      check("t1 done pulse", 32'(done), 32'd0);

      // ---- ready toggling 1,0,0,1 ----
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      dones = 0;
      while (n < 80) begin
         out_ready = pat[n % 4];
         if (out_valid && out_ready) begin
            got_idx.push_back(int'(out_index));
            got_dat.push_back(int'(out_data));
         end
         tick();
         n++;
         if (done) begin
            dones++;
            break;
         end
      end
      if (n >= 80) timeout_fail("t2 frame");
      check("t2 word count", 32'(got_idx.size()), 32'd8);
      for (int i = 0; i < got_idx.size(); i++) begin
         check("t2 index", 32'(got_idx[i]), 32'(i));
         check("t2 data", 32'(got_dat[i]), 32'(i + 3));
      end
      check("t2 done count", 32'(dones), 32'd1);
      out_ready = 1'b1;
      tick();
      check("t2 single done", 32'(done), 32'd0);

      // ---- abort with index 4 stalled ----
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_index(3'd4);
      out_ready = 1'b0;
      tick();
      check("t3 stalled valid", 32'(out_valid), 32'd1);
      check("t3 stalled index", 32'(out_index), 32'd4);
      abort = 1'b1;
      out_ready = 1'b1;
      tick();
      abort = 1'b0;
      check("t3 abort valid", 32'(out_valid), 32'd0);
      check("t3 abort busy", 32'(busy), 32'd0);
      check("t3 abort done", 32'(done), 32'd0);
      tick();
      check("t3 no late done", 32'(done), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t3 restart valid", 32'(out_valid), 32'd1);
      check("t3 restart index", 32'(out_index), 32'd0);
      wait_done();
      tick();

      // ---- start during SCAN ignored, start in done cycle accepted ----
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_index(3'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4 ignored start index", 32'(out_index), 32'd3);
      check("t4 ignored start busy", 32'(busy), 32'd1);
      wait_done();
      check("t4 done seen", 32'(done), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4 b2b busy", 32'(busy), 32'd1);
      check("t4 b2b valid", 32'(out_valid), 32'd0);
      tick();
      check("t4 b2b first valid", 32'(out_valid), 32'd1);
      check("t4 b2b first index", 32'(out_index), 32'd0);
      wait_done();
      tick();

      // ---- asynchronous reset mid-sweep ----
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_index(3'd5);
      #2 rst_n = 1'b0;
      #1;
      check("t5 async valid", 32'(out_valid), 32'd0);
      check("t5 async busy", 32'(busy), 32'd0);
      check("t5 async addr", 32'(ram_rd_addr), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) tick();
      check("t5 idle busy", 32'(busy), 32'd0);
      check("t5 idle valid", 32'(out_valid), 32'd0);
      check("t5 idle done", 32'(done), 32'd0);

`ifdef SPECTRUM_READER_PEAK_EN
      // ---- peak search ----
      check("t6 peak_valid after reset", 32'(peak_valid), 32'd0);
      ram[0] = 4'd1; ram[1] = 4'd9; ram[2] = 4'd4; ram[3] = 4'd9;
      ram[4] = 4'd2; ram[5] = 4'd0; ram[6] = 4'd7; ram[7] = 4'd3;
      pk_val = int'(ram[0]);
      pk_idx = 0;
      for (int i = 1; i < DEPTH; i++) begin
         if (int'(ram[i]) > pk_val) begin
            pk_val = int'(ram[i]);
            pk_idx = i;
         end
      end
      check("t6 model pins value", 32'(pk_val), 32'd9);
      check("t6 model pins index", 32'(pk_idx), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      check("t6 peak_valid", 32'(peak_valid), 32'd1);
      check("t6 peak_value", 32'(peak_value), 32'(pk_val));
      check("t6 peak_index", 32'(peak_index), 32'(pk_idx));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6 peak_valid cleared", 32'(peak_valid), 32'd0);
      wait_done();
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
